// File: rtl/mac_stream_pkg.sv
// Shared types for the MAC stream feeder: pair layout, feeder states and beat width.
package mac_stream_pkg;

   localparam int unsigned DataWidth = 2;
   localparam int unsigned BeatWidth = 2 * DataWidth;

   typedef struct packed {
      logic signed [DataWidth-1:0] inp;
      logic signed [DataWidth-1:0] weight;
   } pair_t;

   typedef enum logic [1:0] {
      StIdle,
      StSendBias,
      StSendPairs,
      StWaitResult
   } feeder_state_e;

endpackage

// File: rtl/pair_word_serializer.sv
// Buffers one packed pair word at a time and hands its lanes out in order, lane 0 first,
// stopping after the commanded number of pairs.
module pair_word_serializer
   import mac_stream_pkg::*;
#(
   parameter int unsigned C_DATA_WIDTH     = DataWidth,
   parameter int unsigned C_PAIRS_PER_WORD = 4,
   parameter int unsigned C_COUNT_WIDTH    = 16
) (
   input  logic                                         i_clk,
   input  logic                                         i_rst,
   input  logic                                         i_start,
   input  logic [C_COUNT_WIDTH-1:0]                     i_count,
   input  logic                                         i_enable,
   input  logic                                         i_word_valid,
   output logic                                         o_word_ready,
   input  logic [C_PAIRS_PER_WORD*2*C_DATA_WIDTH-1:0]   i_word,
   output logic                                         o_pair_valid,
   input  logic                                         i_pair_ready,
   output logic [2*C_DATA_WIDTH-1:0]                    o_pair,
   output logic                                         o_pair_last
);

   localparam int unsigned BW    = 2 * C_DATA_WIDTH;
   localparam int unsigned WW    = C_PAIRS_PER_WORD * BW;
   localparam int unsigned LaneW = (C_PAIRS_PER_WORD > 1) ? $clog2(C_PAIRS_PER_WORD) : 1;

   logic [WW-1:0]            r_word,       w_word_nxt;
   logic                     r_buf_valid,  w_buf_valid_nxt;
   logic [LaneW-1:0]         r_lane,       w_lane_nxt;
   logic [C_COUNT_WIDTH-1:0] r_pairs_left, w_pairs_left_nxt;
   logic [C_COUNT_WIDTH-1:0] r_req_left,   w_req_left_nxt;

   logic                     w_pair_fire;
   logic                     w_word_fire;
   logic                     w_last_lane;
   logic                     w_word_free;
   logic [C_COUNT_WIDTH-1:0] w_take;

   assign w_pair_fire = r_buf_valid && i_pair_ready;
   // A word is finished either at its top lane or when the final pair leaves a partial word.
   assign w_last_lane = (r_lane == LaneW'(C_PAIRS_PER_WORD - 1)) ||
                        (r_pairs_left == C_COUNT_WIDTH'(1));
   assign w_word_free = !r_buf_valid || (w_pair_fire && w_last_lane);

   // r_req_left counts pairs not yet covered by an accepted word, so requests stop at ceil(N/P).
   assign o_word_ready = i_enable && (r_req_left != '0) && w_word_free;
   assign w_word_fire  = i_word_valid && o_word_ready;
   assign w_take       = (r_req_left > C_COUNT_WIDTH'(C_PAIRS_PER_WORD)) ?
                         C_COUNT_WIDTH'(C_PAIRS_PER_WORD) : r_req_left;

   assign o_pair_valid = r_buf_valid;
   assign o_pair       = r_word[BW*int'(r_lane) +: BW];
   assign o_pair_last  = (r_pairs_left == C_COUNT_WIDTH'(1));

   always_comb begin
      w_word_nxt       = r_word;
      w_buf_valid_nxt  = r_buf_valid;
      w_lane_nxt       = r_lane;
      w_pairs_left_nxt = r_pairs_left;
      w_req_left_nxt   = r_req_left;
      if (i_start) begin
         w_buf_valid_nxt  = 1'b0;
         w_lane_nxt       = '0;
         w_pairs_left_nxt = i_count;
         w_req_left_nxt   = i_count;
      end else begin
         if (w_pair_fire) begin
            w_pairs_left_nxt = r_pairs_left - C_COUNT_WIDTH'(1);
            if (w_last_lane) begin
               w_lane_nxt      = '0;
               w_buf_valid_nxt = 1'b0;
            end else begin
               w_lane_nxt = r_lane + LaneW'(1);
            end
         end
         if (w_word_fire) begin
            w_word_nxt      = i_word;
            w_buf_valid_nxt = 1'b1;
            w_req_left_nxt  = r_req_left - w_take;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_word       <= '0;
         r_buf_valid  <= 1'b0;
         r_lane       <= '0;
         r_pairs_left <= '0;
         r_req_left   <= '0;
      end else begin
         r_word       <= w_word_nxt;
         r_buf_valid  <= w_buf_valid_nxt;
         r_lane       <= w_lane_nxt;
         r_pairs_left <= w_pairs_left_nxt;
         r_req_left   <= w_req_left_nxt;
      end
   end

endmodule

// File: rtl/mac_stream_feeder.sv
// Drives the bias-then-pairs AXI-Stream sequence into the MAC and captures its single
// 32-bit result beat. One command is outstanding at a time.
module mac_stream_feeder
   import mac_stream_pkg::*;
#(
   parameter int unsigned C_DATA_WIDTH     = DataWidth,
   parameter int unsigned C_PAIRS_PER_WORD = 4,
   parameter int unsigned C_COUNT_WIDTH    = 16
) (
   input  logic                                        ACLK,
   input  logic                                        ARESET,
   input  logic                                        CMD_VALID,
   output logic                                        CMD_READY,
   input  logic [2*C_DATA_WIDTH-1:0]                   CMD_BIAS,
   input  logic [C_COUNT_WIDTH-1:0]                    CMD_COUNT,
   input  logic                                        PW_VALID,
   output logic                                        PW_READY,
   input  logic [C_PAIRS_PER_WORD*2*C_DATA_WIDTH-1:0]  PW_DATA,
   output logic                                        M_AXIS_TVALID,
   input  logic                                        M_AXIS_TREADY,
   output logic [2*C_DATA_WIDTH-1:0]                   M_AXIS_TDATA,
   output logic                                        M_AXIS_TLAST,
   output logic                                        M_AXIS_TUSER,
   output logic [7:0]                                  M_AXIS_TID,
   input  logic                                        S_AXIS_TVALID,
   output logic                                        S_AXIS_TREADY,
   input  logic [31:0]                                 S_AXIS_TDATA,
   input  logic                                        S_AXIS_TLAST,
   output logic                                        RESULT_VALID,
   output logic [31:0]                                 RESULT_DATA,
   output logic                                        BUSY
);

   localparam int unsigned BW = 2 * C_DATA_WIDTH;

   feeder_state_e r_state, w_state_nxt;

   logic          r_tvalid,       w_tvalid_nxt;
   logic [BW-1:0] r_tdata,        w_tdata_nxt;
   logic          r_tlast,        w_tlast_nxt;
   logic          r_result_valid, w_result_valid_nxt;
   logic [31:0]   r_result,       w_result_nxt;

   logic          w_cmd_fire;
   logic          w_out_fire;
   logic          w_res_fire;
   logic          w_ser_enable;
   logic          w_pair_valid;
   logic          w_pair_ready;
   logic          w_pair_fire;
   logic          w_pair_last;
   logic [BW-1:0] w_pair;
   logic          w_unused_tlast;

   assign w_unused_tlast = S_AXIS_TLAST;

   assign CMD_READY     = (r_state == StIdle) && !ARESET;
   assign S_AXIS_TREADY = (r_state == StWaitResult) && !ARESET;
   assign w_cmd_fire    = CMD_VALID && CMD_READY;
   assign w_out_fire    = r_tvalid && M_AXIS_TREADY;
   assign w_res_fire    = S_AXIS_TVALID && S_AXIS_TREADY;

   // Refill the output register in the same cycle it drains to keep one beat per cycle.
   assign w_ser_enable  = (r_state == StSendPairs) && !ARESET;
   assign w_pair_ready  = w_ser_enable && (!r_tvalid || M_AXIS_TREADY);
   assign w_pair_fire   = w_pair_valid && w_pair_ready;

   pair_word_serializer #(
      .C_DATA_WIDTH     (C_DATA_WIDTH),
      .C_PAIRS_PER_WORD (C_PAIRS_PER_WORD),
      .C_COUNT_WIDTH    (C_COUNT_WIDTH)
   ) u_serializer (
      .i_clk        (ACLK),
      .i_rst        (ARESET),
      .i_start      (w_cmd_fire),
      .i_count      (CMD_COUNT),
      .i_enable     (w_ser_enable),
      .i_word_valid (PW_VALID),
      .o_word_ready (PW_READY),
      .i_word       (PW_DATA),
      .o_pair_valid (w_pair_valid),
      .i_pair_ready (w_pair_ready),
      .o_pair       (w_pair),
      .o_pair_last  (w_pair_last)
   );

   always_comb begin
      w_state_nxt        = r_state;
      w_tvalid_nxt       = r_tvalid;
      w_tdata_nxt        = r_tdata;
      w_tlast_nxt        = r_tlast;
      w_result_valid_nxt = 1'b0;
      w_result_nxt       = r_result;
      case (r_state)
         StIdle: begin
            if (w_cmd_fire) begin
               w_tvalid_nxt = 1'b1;
               w_tdata_nxt  = CMD_BIAS;
               w_tlast_nxt  = (CMD_COUNT == '0);
               w_state_nxt  = StSendBias;
            end
         end
         StSendBias: begin
            if (w_out_fire) begin
               w_tvalid_nxt = 1'b0;
               w_state_nxt  = r_tlast ? StWaitResult : StSendPairs;
            end
         end
         StSendPairs: begin
            if (w_out_fire) begin
               w_tvalid_nxt = 1'b0;
               if (r_tlast) begin
                  w_state_nxt = StWaitResult;
               end
            end
            if (w_pair_fire) begin
               w_tvalid_nxt = 1'b1;
               w_tdata_nxt  = w_pair;
               w_tlast_nxt  = w_pair_last;
            end
         end
         StWaitResult: begin
            if (w_res_fire) begin
               w_result_nxt       = S_AXIS_TDATA;
               w_result_valid_nxt = 1'b1;
               w_state_nxt        = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state        <= StIdle;
         r_tvalid       <= 1'b0;
         r_tdata        <= '0;
         r_tlast        <= 1'b0;
         r_result_valid <= 1'b0;
         r_result       <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_tvalid       <= w_tvalid_nxt;
         r_tdata        <= w_tdata_nxt;
         r_tlast        <= w_tlast_nxt;
         r_result_valid <= w_result_valid_nxt;
         r_result       <= w_result_nxt;
      end
   end

   assign M_AXIS_TVALID = r_tvalid;
   assign M_AXIS_TDATA  = r_tdata;
   assign M_AXIS_TLAST  = r_tlast;
   assign M_AXIS_TUSER  = 1'b0;
   assign M_AXIS_TID    = 8'd0;
   assign RESULT_VALID  = r_result_valid;
   assign RESULT_DATA   = r_result;
   assign BUSY          = (r_state != StIdle);

endmodule
